// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// port index constants used by the top level and the round-robin picker.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arbState_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker. When both ports request, the port that was
// not granted last wins; a sole requester always wins.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    // Pick the winner and raise its one-hot grant; no grant when idle.
    always_comb begin
        gnt    = 2'b00;
        winner = last;
        if (req[0] && req[1]) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = PORT1;
        end else if (req[0]) begin
            winner = PORT0;
        end
        if (req != 2'b00) begin
            gnt = (winner == PORT1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the
// MEM stage (port 0) and a secondary master (port 1), with bounded locked
// bursts and a one-cycle registered read response per port.
//
// Handshake: req acts as valid and gnt as ready. A requester holds req and
// its payload (we/addr/wdata/lock) stable until gnt; the access happens at
// the rising edge closing the cycle in which req and gnt are both high.
// Dropping req before gnt withdraws the request with no side effect.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbgState
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    arbState_t     state, stateNext;
    logic          last, lastNext;
    logic [CW-1:0] burstCnt, burstNext;
    logic [1:0]    pickGnt;
    logic          pickWinner;
    logic          winLock;
    logic          cont0, cont1;
    logic          selPort;

    rr_pick2 uPick (
        .req    ({p1_req, p0_req}),
        .last   (last),
        .gnt    (pickGnt),
        .winner (pickWinner)
    );

    // A locked owner keeps the memory while it still asks and has burst budget.
    assign cont0 = (state == LOCK0) && p0_req && p0_lock && (burstCnt < BURST_MAX);
    assign cont1 = (state == LOCK1) && p1_req && p1_lock && (burstCnt < BURST_MAX);

    // Next-state, grant and burst-count decision.
    always_comb begin
        stateNext = IDLE;
        burstNext = '0;
        lastNext  = last;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        winLock   = 1'b0;
        if (cont0) begin
            p0_gnt    = 1'b1;
            stateNext = LOCK0;
            burstNext = burstCnt + CW'(1);
            lastNext  = PORT0;
        end else if (cont1) begin
            p1_gnt    = 1'b1;
            stateNext = LOCK1;
            burstNext = burstCnt + CW'(1);
            lastNext  = PORT1;
        end else if (pickGnt != 2'b00) begin
            // Forced release falls out naturally: last already names the
            // owner, so the peer wins if it is asking.
            p0_gnt   = pickGnt[0];
            p1_gnt   = pickGnt[1];
            lastNext = pickWinner;
            winLock  = (pickWinner == PORT1) ? p1_lock : p0_lock;
            if (winLock) begin
                stateNext = (pickWinner == PORT1) ? LOCK1 : LOCK0;
                burstNext = CW'(1);
            end
        end
    end

    // Memory-side mux follows the granted port, otherwise the last owner.
    assign selPort   = p1_gnt ? PORT1 : (p0_gnt ? PORT0 : last);
    assign mem_adr   = (selPort == PORT1) ? p1_addr  : p0_addr;
    assign mem_wdata = (selPort == PORT1) ? p1_wdata : p0_wdata;
    assign mem_write = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    assign dbgState  = state;

    // FSM, round-robin pointer and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= PORT1;
            burstCnt <= '0;
        end else begin
            state    <= stateNext;
            last     <= lastNext;
            burstCnt <= burstNext;
        end
    end

    // Registered read responses: capture on a granted read, pulse rvalid once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_rdata;
            if (p1_gnt && !p1_we) p1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a behavioural
// word-addressed memory hanging off the memory-side pins.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_BURST = 4;
  localparam int NVEC = 16;

  logic          clk, rst_n;
  logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write;
  logic [1:0]    dbg_state;

  // memory model plus a preload port used only while the arbiter is idle
  logic [DW-1:0] mem [0:255];
  logic          pre_we;
  logic [7:0]    pre_idx;
  logic [DW-1:0] pre_data;

  int n_checks, n_fail;

  typedef struct {
    bit          rst;
    logic        p0_req, p0_we, p0_lock;
    logic [31:0] p0_addr, p0_wdata;
    logic        p1_req, p1_we, p1_lock;
    logic [31:0] p1_addr, p1_wdata;
    logic        e_g0, e_g1, e_mw;
    logic [31:0] e_adr;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs [NVEC];

  logic [DW-1:0] exp_q0[$], exp_q1[$];
  logic          rv0_exp, rv1_exp, g0_last, g1_last;
  int            waited;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .dbgState(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  assign mem_rdata = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_adr[9:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst,
      input logic a_req, input logic a_we, input logic a_lock, input logic [31:0] a_addr, input logic [31:0] a_wd,
      input logic b_req, input logic b_we, input logic b_lock, input logic [31:0] b_addr, input logic [31:0] b_wd,
      input logic g0, input logic g1, input logic mw, input logic [31:0] adr, input logic [1:0] st);
    vec_t v;
    v.rst = rst;
    v.p0_req = a_req; v.p0_we = a_we; v.p0_lock = a_lock; v.p0_addr = a_addr; v.p0_wdata = a_wd;
    v.p1_req = b_req; v.p1_we = b_we; v.p1_lock = b_lock; v.p1_addr = b_addr; v.p1_wdata = b_wd;
    v.e_g0 = g0; v.e_g1 = g1; v.e_mw = mw; v.e_adr = adr; v.e_state = st;
    return v;
  endfunction

  // driver tasks (entered and left just after a rising edge)
  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_read(input logic port, input logic [31:0] addr, input logic [31:0] exp,
                         input string nm, output int wcyc);
    bit got;
    got = 0;
    wcyc = 0;
    if (port) begin p1_req = 1; p1_we = 0; p1_lock = 0; p1_addr = addr; end
    else      begin p0_req = 1; p0_we = 0; p0_lock = 0; p0_addr = addr; end
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if ((port ? p1_gnt : p0_gnt) === 1'b1) got = 1;
      else wcyc++;
      @(posedge clk); #1;
    end
    p0_req = 0;
    p1_req = 0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_gnt actual=no grant required=grant within 8 cycles", nm);
    end else begin
      @(negedge clk);
      checkb({nm, "_rvalid"}, port ? p1_rvalid : p0_rvalid, 1'b1);
      check({nm, "_rdata"}, port ? p1_rdata : p0_rdata, exp);
      checkb({nm, "_other_rvalid"}, port ? p0_rvalid : p1_rvalid, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clear_inputs();
    pre_we = 1'b1;
    pre_idx = 8'd4;
    pre_data = 32'hDEADBEEF;

    // contention (rows 0-3), locked burst vs busy peer (4-9), locked burst with idle peer (10-15)
    vecs[0]  = mk(1, 1,1,0,32'h100,32'h11111111, 1,1,0,32'h200,32'h22222222, 1,0,1,32'h100,IDLE);
    vecs[1]  = mk(0, 1,1,0,32'h100,32'h11111111, 1,1,0,32'h200,32'h22222222, 0,1,1,32'h200,IDLE);
    vecs[2]  = mk(0, 1,1,0,32'h100,32'h11111111, 1,1,0,32'h200,32'h22222222, 1,0,1,32'h100,IDLE);
    vecs[3]  = mk(0, 1,1,0,32'h100,32'h11111111, 1,1,0,32'h200,32'h22222222, 0,1,1,32'h200,IDLE);
    vecs[4]  = mk(1, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 1,0,1,32'h040,IDLE);
    vecs[5]  = mk(0, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 1,0,1,32'h040,LOCK0);
    vecs[6]  = mk(0, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 1,0,1,32'h040,LOCK0);
    vecs[7]  = mk(0, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 1,0,1,32'h040,LOCK0);
    vecs[8]  = mk(0, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 0,1,0,32'h200,LOCK0);
    vecs[9]  = mk(0, 1,1,1,32'h040,32'h33333333, 1,0,0,32'h200,32'h0, 1,0,1,32'h040,IDLE);
    vecs[10] = mk(1, 1,0,1,32'h010,32'h0, 0,0,0,32'h0,32'h0, 1,0,0,32'h010,IDLE);
    for (int i = 11; i < NVEC; i++)
      vecs[i] = mk(0, 1,0,1,32'h010,32'h0, 0,0,0,32'h0,32'h0, 1,0,0,32'h010,LOCK0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pre_we = 1'b0;
    @(negedge clk);
    checkb("rst_p0_gnt", p0_gnt, 1'b0);
    checkb("rst_p1_gnt", p1_gnt, 1'b0);
    checkb("rst_mem_write", mem_write, 1'b0);
    checkb("rst_p0_rvalid", p0_rvalid, 1'b0);
    checkb("rst_p1_rvalid", p1_rvalid, 1'b0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;

    // single read on port 0, granted in the cycle it is raised
    do_read(1'b0, 32'h10, 32'hDEADBEEF, "rd0", waited);
    check("rd0_latency", 32'(waited), 32'd0);

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst) do_reset();
      p0_req = vecs[i].p0_req; p0_we = vecs[i].p0_we; p0_lock = vecs[i].p0_lock;
      p0_addr = vecs[i].p0_addr; p0_wdata = vecs[i].p0_wdata;
      p1_req = vecs[i].p1_req; p1_we = vecs[i].p1_we; p1_lock = vecs[i].p1_lock;
      p1_addr = vecs[i].p1_addr; p1_wdata = vecs[i].p1_wdata;
      @(negedge clk);
      checkb($sformatf("vec%0d_p0_gnt", i), p0_gnt, vecs[i].e_g0);
      checkb($sformatf("vec%0d_p1_gnt", i), p1_gnt, vecs[i].e_g1);
      checkb($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].e_mw);
      check($sformatf("vec%0d_mem_adr", i), mem_adr, vecs[i].e_adr);
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
      @(posedge clk); #1;
    end
    clear_inputs();

    // readback of the contention and burst writes
    do_read(1'b0, 32'h100, 32'h11111111, "rb_p0_100", waited);
    do_read(1'b1, 32'h200, 32'h22222222, "rb_p1_200", waited);
    do_read(1'b0, 32'h040, 32'h33333333, "rb_p0_040", waited);

    // reset while a port 1 read response is pending
    do_reset();
    p1_req = 1; p1_we = 0; p1_addr = 32'h200;
    @(negedge clk);
    checkb("mr_gnt", p1_gnt, 1'b1);
    @(posedge clk); #1;
    p1_req = 0;
    @(negedge clk);
    checkb("mr_rvalid_pre", p1_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkb("mr_rvalid", p1_rvalid, 1'b0);
    check("mr_rdata", p1_rdata, 32'h0);
    check("mr_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 32'h100;
    p1_req = 1; p1_we = 0; p1_addr = 32'h200;
    @(negedge clk);
    checkb("mr_first_p0_gnt", p0_gnt, 1'b1);
    checkb("mr_first_p1_gnt", p1_gnt, 1'b0);
    @(posedge clk); #1;

    // random protocol-respecting traffic
    do_reset();
    rv0_exp = 0; rv1_exp = 0; g0_last = 0; g1_last = 0;
    exp_q0.delete();
    exp_q1.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (p0_req && !g0_last) begin
        if ($urandom_range(0, 3) == 0) p0_req = 0;
      end else begin
        p0_req = 1'($urandom_range(0, 1));
        p0_we = 1'($urandom_range(0, 1));
        p0_lock = ($urandom_range(0, 2) != 0);
        p0_addr = 32'($urandom_range(0, 255)) << 2;
        p0_wdata = $urandom;
      end
      if (p1_req && !g1_last) begin
        if ($urandom_range(0, 3) == 0) p1_req = 0;
      end else begin
        p1_req = 1'($urandom_range(0, 1));
        p1_we = 1'($urandom_range(0, 1));
        p1_lock = ($urandom_range(0, 2) != 0);
        p1_addr = 32'($urandom_range(0, 255)) << 2;
        p1_wdata = $urandom;
      end
      @(negedge clk);
      g0_last = p0_gnt;
      g1_last = p1_gnt;
      checkb("rnd_excl", p0_gnt & p1_gnt, 1'b0);
      checkb("rnd_write_no_gnt", mem_write & ~(p0_gnt | p1_gnt), 1'b0);
      checkb("rnd_gnt_when_req", p0_gnt | p1_gnt, p0_req | p1_req);
      checkb("rnd_p0_rvalid", p0_rvalid, rv0_exp);
      checkb("rnd_p1_rvalid", p1_rvalid, rv1_exp);
      if (p0_rvalid === 1'b1) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rnd_p0_rdata actual=unexpected rvalid required=none");
        end else check("rnd_p0_rdata", p0_rdata, exp_q0.pop_front());
      end
      if (p1_rvalid === 1'b1) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rnd_p1_rdata actual=unexpected rvalid required=none");
        end else check("rnd_p1_rdata", p1_rdata, exp_q1.pop_front());
      end
      rv0_exp = p0_gnt & ~p0_we & p0_req;
      rv1_exp = p1_gnt & ~p1_we & p1_req;
      if (rv0_exp) exp_q0.push_back(mem[p0_addr[9:2]]);
      if (rv1_exp) exp_q1.push_back(mem[p1_addr[9:2]]);
      @(posedge clk); #1;
    end
    clear_inputs();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
